assert_frame_sched: RTL and testbench

ASSERT_FRAME_SCHED -- requirements
Module: assert_frame_sched

---
 rtl/assert_frame_sched.sv | 145 ++++++++++++++
 tb/tb_assert_frame_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/assert_frame_sched.sv
// Shared frame-window checker: round-robin arbitration of four requesters onto one window timer.
// Optional macro ASSERT_FRAME_SCHED_PENDING_EN queues losing/non-owner request edges for later service.
module assert_frame_sched #(
    parameter int min_cks = 1,
    parameter int max_cks = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] start_event,
    input  logic [3:0] test_expr,
    output logic [3:0] grant,
    output logic       busy,
    output logic       fire_early,
    output logic       fire_late,
    output logic [1:0] fire_id
);

    localparam int CNT_TOP = (min_cks > max_cks) ? min_cks : max_cks;
    localparam int CW      = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);
    localparam logic [CW-1:0] MIN_C = CW'(min_cks);
    localparam logic [CW-1:0] MAX_C = CW'(max_cks);

    if (min_cks > max_cks && max_cks > 0) begin : ovl_error_t
        $error("Illegal parameter values set where min_cks > max_cks");
    end

    typedef enum logic {IDLE, WINDOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    r_start_q, r_start_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    grant_q, grant_d;
    logic          fire_early_q, fire_early_d;
    logic          fire_late_q, fire_late_d;
    logic [1:0]    fire_id_q, fire_id_d;
    logic [1:0]    last_grant_q, last_grant_d;

    logic [3:0] edge_v;
    logic [3:0] req;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        r_start_d    = start_event;
        pending_d    = pending_q;
        grant_d      = grant_q;
        fire_early_d = 1'b0;
        fire_late_d  = 1'b0;
        fire_id_d    = fire_id_q;
        last_grant_d = last_grant_q;
        idx          = '0;
        win          = '0;
        found        = 1'b0;

        // A start edge arriving together with its completion condition is not a request.
        edge_v = start_event & ~r_start_q & ~test_expr;
`ifdef ASSERT_FRAME_SCHED_PENDING_EN
        req = edge_v | pending_q;
`else
        req = edge_v;
`endif

        for (int unsigned k = 0; k < 4; k++) begin
            idx = last_grant_q + 2'(k + 1);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = WINDOW;
                    cnt_d        = CW'(1);
                    grant_d      = 4'b0001 << win;
                    last_grant_d = win;
`ifdef ASSERT_FRAME_SCHED_PENDING_EN
                    pending_d = req & ~(4'b0001 << win);
`endif
                end
            end
            WINDOW: begin
`ifdef ASSERT_FRAME_SCHED_PENDING_EN
                pending_d = pending_q | (edge_v & ~grant_q);
`endif
                if (edge_v[last_grant_q]) begin
                    cnt_d = CW'(1);
                end else if (test_expr[last_grant_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    grant_d = '0;
                    if (cnt_q < MIN_C) begin
                        fire_early_d = 1'b1;
                        fire_id_d    = last_grant_q;
                    end
                end else if (max_cks > 0 && cnt_q == MAX_C) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    grant_d     = '0;
                    fire_late_d = 1'b1;
                    fire_id_d   = last_grant_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            r_start_q    <= '0;
            pending_q    <= '0;
            grant_q      <= '0;
            fire_early_q <= 1'b0;
            fire_late_q  <= 1'b0;
            fire_id_q    <= '0;
            last_grant_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            r_start_q    <= r_start_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            fire_early_q <= fire_early_d;
            fire_late_q  <= fire_late_d;
            fire_id_q    <= fire_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == WINDOW);
    assign fire_early = fire_early_q;
    assign fire_late  = fire_late_q;
    assign fire_id    = fire_id_q;

endmodule

// File: tb/tb_assert_frame_sched.sv
// Table-driven bench for assert_frame_sched (min_cks=2, max_cks=4); each row's expectation
// is the output observed one cycle after its inputs are applied.
module tb_assert_frame_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] start_event;
    logic [3:0] test_expr;
    logic [3:0] grant;
    logic       busy;
    logic       fire_early;
    logic       fire_late;
    logic [1:0] fire_id;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic [3:0] st;
        logic [3:0] te;
        logic [3:0] g;
        logic       b;
        logic       e;
        logic       l;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    assert_frame_sched #(.min_cks(2), .max_cks(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_event (start_event),
        .test_expr   (test_expr),
        .grant       (grant),
        .busy        (busy),
        .fire_early  (fire_early),
        .fire_late   (fire_late),
        .fire_id     (fire_id)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic rst, input logic [3:0] st, input logic [3:0] te,
                       input logic [3:0] g, input logic b, input logic e, input logic l,
                       input logic [1:0] id);
        vec_t v;
        v.rst = rst; v.st = st; v.te = te;
        v.g = g; v.b = b; v.e = e; v.l = l; v.id = id;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] g, input logic b,
                       input logic e, input logic l, input logic [1:0] id);
        vectors++;
        if (grant !== g || busy !== b || fire_early !== e || fire_late !== l || fire_id !== id) begin
            miscompares++;
            $display("FAIL %s: got grant=%b busy=%b early=%b late=%b id=%0d, want grant=%b busy=%b early=%b late=%b id=%0d",
                     name, grant, busy, fire_early, fire_late, fire_id, g, b, e, l, id);
        end
    endtask

    initial begin
        vec_t x;
        reset_n     = 1'b0;
        start_event = '0;
        test_expr   = '0;

        // pass: window closes at cnt=3
        add(1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0);
        add(1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0);
        add(1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0);
        add(1, 4'h1, 4'h1, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        // early
        add(1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0);
        add(1, 4'h1, 4'h1, 4'h0, 0, 1, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        // late on requester 2
        add(1, 4'h4, 4'h0, 4'h4, 1, 0, 0, 0);
        add(1, 4'h4, 4'h0, 4'h4, 1, 0, 0, 0);
        add(1, 4'h4, 4'h0, 4'h4, 1, 0, 0, 0);
        add(1, 4'h4, 4'h0, 4'h4, 1, 0, 0, 0);
        add(1, 4'h4, 4'h0, 4'h0, 0, 0, 1, 2);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2);
        // test_expr exactly at cnt==max_cks is a pass
        add(1, 4'h8, 4'h0, 4'h8, 1, 0, 0, 2);
        add(1, 4'h8, 4'h0, 4'h8, 1, 0, 0, 2);
        add(1, 4'h8, 4'h0, 4'h8, 1, 0, 0, 2);
        add(1, 4'h8, 4'h0, 4'h8, 1, 0, 0, 2);
        add(1, 4'h8, 4'h8, 4'h0, 0, 0, 0, 2);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2);
        // owner re-start reloads the counter
        add(1, 4'h2, 4'h0, 4'h2, 1, 0, 0, 2);
        add(1, 4'h2, 4'h0, 4'h2, 1, 0, 0, 2);
        add(1, 4'h0, 4'h0, 4'h2, 1, 0, 0, 2);
        add(1, 4'h2, 4'h0, 4'h2, 1, 0, 0, 2);
        add(1, 4'h2, 4'h0, 4'h2, 1, 0, 0, 2);
        add(1, 4'h2, 4'h0, 4'h2, 1, 0, 0, 2);
        add(1, 4'h2, 4'h0, 4'h2, 1, 0, 0, 2);
        add(1, 4'h2, 4'h0, 4'h0, 0, 0, 1, 1);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
        // reset restores last_grant=3 and clears fire_id
        add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        // simultaneous requests 1 and 2
        add(1, 4'h6, 4'h0, 4'h2, 1, 0, 0, 0);
        add(1, 4'h6, 4'h0, 4'h2, 1, 0, 0, 0);
        add(1, 4'h6, 4'h2, 4'h0, 0, 0, 0, 0);
`ifdef ASSERT_FRAME_SCHED_PENDING_EN
        add(1, 4'h6, 4'h0, 4'h4, 1, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h4, 1, 0, 0, 0);
        add(1, 4'h0, 4'h4, 4'h0, 0, 0, 0, 0);
`else
        add(1, 4'h6, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h4, 4'h0, 0, 0, 0, 0);
`endif
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        // requester 3 starts while owner 0 is busy
        add(1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 0);
        add(1, 4'h9, 4'h0, 4'h1, 1, 0, 0, 0);
        add(1, 4'h9, 4'h1, 4'h0, 0, 0, 0, 0);
`ifdef ASSERT_FRAME_SCHED_PENDING_EN
        add(1, 4'h9, 4'h0, 4'h8, 1, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h8, 1, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h8, 1, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h8, 1, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 3);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 3);
`else
        add(1, 4'h9, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
`endif

        repeat (2) @(negedge clk);
        chk("reset_state", 4'h0, 0, 0, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk($sformatf("row%0d", i - 1), x.g, x.b, x.e, x.l, x.id);
            end
            reset_n     = vecs[i].rst;
            start_event = vecs[i].st;
            test_expr   = vecs[i].te;
            exp_q.push_back(vecs[i]);
        end
        @(negedge clk);
        x = exp_q.pop_front();
        chk($sformatf("row%0d", vecs.size() - 1), x.g, x.b, x.e, x.l, x.id);

        // asynchronous reset in the middle of a window
        start_event = 4'h2;
        test_expr   = 4'h0;
        @(negedge clk);
        chk("midreset_grant", 4'h2, 1, 0, 0, fire_id_exp());
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_async", 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n     = 1'b1;
        start_event = 4'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset%0d", c), 4'h0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    function automatic logic [1:0] fire_id_exp();
`ifdef ASSERT_FRAME_SCHED_PENDING_EN
        return 2'd3;
`else
        return 2'd0;
`endif
    endfunction

endmodule
